// File: rtl/dual_range_bus_rx_pkg.sv
// Shared constants, state type and mirror-check helper for the dual-range bus pair.
// i0 is declared [2:-2] and i1 is declared [-2:2]; index k names the same wire on both buses.
package dual_range_bus_pkg;

  localparam int BUS_HI = 2;
  localparam int BUS_LO = -2;
  localparam int BUS_W  = 5;
  localparam int WORD_W = 10;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } rx_state_e;

  // Compares by declared index, so a pass means the positional fields are bit-reversed copies.
  function automatic logic mirror_ok(input logic [BUS_HI:BUS_LO] a,
                                     input logic [BUS_LO:BUS_HI] b);
    mirror_ok = (a[2]  == b[2])  &&
                (a[1]  == b[1])  &&
                (a[0]  == b[0])  &&
                (a[-1] == b[-1]) &&
                (a[-2] == b[-2]);
  endfunction

endpackage

// File: rtl/dual_range_bus_rx_fifo.sv
// Parameterised synchronous FIFO with extra-bit wrap pointers; shared with the transmitter side.
// The head entry is shown on data_o one cycle after it is written; there is no bypass path.
module dual_range_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is not reset; the empty gate below keeps stale entries off the output.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/dual_range_bus_rx.sv
// Receiver for the dual-range bus pair: handshake capture, mirror check, error tracking
// and a FIFO presenting {i0, i1} as a flat 10-bit stream.
module dual_range_bus_rx
  import dual_range_bus_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int CHECK_EN    = 1,
  parameter int HALT_ON_ERR = 1,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_HI:BUS_LO] i0,
  input  logic [BUS_LO:BUS_HI] i1,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WORD_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 halted,
  input  logic                 err_clr
);

  rx_state_e         state_q, state_d;
  logic              alive_q;
  logic              mismatch_q, mismatch_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              word_ok;
  logic              bad_word;
  logic [WORD_W-1:0] word;

  assign accept   = in_valid && in_ready;
  assign word_ok  = (CHECK_EN == 0) || mirror_ok(i0, i1);
  assign bad_word = accept && !word_ok;
  // Concatenating the ascending bus places i1[-2] first, giving the required bit order.
  assign word     = {i0, i1};

  dual_range_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .data_i  (word),
    .pop_i   (out_valid && out_ready),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive_q <= 1'b0;
    else        alive_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bad_word && (HALT_ON_ERR != 0)) state_d = HALT;
      HALT:    if (err_clr) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    halted   = (state_q == HALT);
    in_ready = alive_q && (state_q == RUN) && !fifo_full;
  end

  // Clear wins over a coincident mismatch, but the mismatch pulse is still reported.
  always_comb begin
    mismatch_d = bad_word;
    err_cnt_d  = err_cnt_q;
    if (err_clr)
      err_cnt_d = '0;
    else if (bad_word && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid = !fifo_empty;
  assign mismatch  = mismatch_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dual_range_bus_rx.sv
// Self-checking bench for dual_range_bus_rx: queue-based reference model, vector table,
// hand-written corner sequences and randomized traffic.
module tb_dual_range_bus_rx;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [9:0] expOut;
    logic       expMis;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [2:-2] i0;
  logic [-2:2] i1;
  logic        in_valid;
  logic        out_ready;
  logic        err_clr;

  logic        inRdyA, outValidA, misA, haltA;
  logic [9:0]  outDataA;
  logic [7:0]  errA;
  logic        inRdyB, outValidB, misB, haltB;
  logic [9:0]  outDataB;
  logic [1:0]  errB;

  int          passCnt;
  int          totalCnt;

  logic [4:0]  curA, curB;
  logic [9:0]  q[$];
  bit          mHalt, mMis, mAlive;
  int          mErr;
  bit          lastAcc;
  vec_t        vecs[7];

  dual_range_bus_rx #(.DEPTH(4), .CHECK_EN(1), .HALT_ON_ERR(1), .CNT_W(8)) dutA (
    .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .in_valid(in_valid), .in_ready(inRdyA),
    .out_data(outDataA), .out_valid(outValidA), .out_ready(out_ready), .mismatch(misA),
    .err_cnt(errA), .halted(haltA), .err_clr(err_clr)
  );

  dual_range_bus_rx #(.DEPTH(4), .CHECK_EN(1), .HALT_ON_ERR(0), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .in_valid(in_valid), .in_ready(inRdyB),
    .out_data(outDataB), .out_valid(outValidB), .out_ready(out_ready), .mismatch(misB),
    .err_cnt(errB), .halted(haltB), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] rev5(input logic [4:0] x);
    logic [4:0] r;
    for (int k = 0; k < 5; k++) r[k] = x[4-k];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // a is i0 positionally (a[4]=i0[2]); b is i1 positionally (b[4]=i1[-2]).
  task automatic applyStimulus(input logic [4:0] a, input logic [4:0] b, input logic v,
                               input logic ordy, input logic clr);
    curA      = a;
    curB      = b;
    i0        = a;
    i1        = b;
    in_valid  = v;
    out_ready = ordy;
    err_clr   = clr;
  endtask

  task automatic modelReset();
    q.delete();
    mHalt  = 0;
    mMis   = 0;
    mAlive = 0;
    mErr   = 0;
  endtask

  // Compares dutA with the model for the current cycle, then advances both one clock.
  task automatic modelCycle(input string tag);
    bit expRdy, acc, pop, bad;
    expRdy = mAlive && !mHalt && (q.size() < 4);
    checkOutput({tag, ":in_ready"}, inRdyA, expRdy);
    checkOutput({tag, ":out_valid"}, outValidA, q.size() != 0);
    checkOutput({tag, ":out_data"}, outDataA, (q.size() != 0) ? q[0] : 10'd0);
    checkOutput({tag, ":mismatch"}, misA, mMis);
    checkOutput({tag, ":err_cnt"}, errA, mErr);
    checkOutput({tag, ":halted"}, haltA, mHalt);
    acc = in_valid && expRdy;
    pop = out_ready && (q.size() != 0);
    bad = acc && (curB != rev5(curA));
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back({curA, curB});
    mMis = bad;
    if (err_clr) mErr = 0;
    else if (bad && mErr < 255) mErr++;
    if (mHalt && err_clr) mHalt = 0;
    else if (!mHalt && bad) mHalt = 1;
    mAlive  = 1;
    lastAcc = acc;
    #1;
  endtask

  task automatic pulseReset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    logic [4:0] w[6];
    logic [4:0] ra;
    int         idx;
    passCnt  = 0;
    totalCnt = 0;
    vecs[0] = '{5'b10110, 5'b01101, 10'b10110_01101, 1'b0};
    vecs[1] = '{5'b00000, 5'b00000, 10'b00000_00000, 1'b0};
    vecs[2] = '{5'b11111, 5'b11111, 10'b11111_11111, 1'b0};
    vecs[3] = '{5'b10000, 5'b00001, 10'b10000_00001, 1'b0};
    vecs[4] = '{5'b10000, 5'b10000, 10'b10000_10000, 1'b1};
    vecs[5] = '{5'b01100, 5'b00110, 10'b01100_00110, 1'b0};
    vecs[6] = '{5'b11111, 5'b11110, 10'b11111_11110, 1'b1};

    rst_n = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    modelReset();
    #3;
    checkOutput("reset:in_ready", inRdyA, 0);
    checkOutput("reset:out_valid", outValidA, 0);
    checkOutput("reset:out_data", outDataA, 0);
    checkOutput("reset:mismatch", misA, 0);
    checkOutput("reset:err_cnt", errA, 0);
    checkOutput("reset:halted", haltA, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    modelCycle("post-reset");
    checkOutput("ready-after-reset", inRdyA, 1);

    // Single matching word
    applyStimulus(5'b10110, 5'b01101, 1'b1, 1'b1, 1'b0);
    modelCycle("t1-accept");
    checkOutput("t1-data", outDataA, 10'b10110_01101);
    checkOutput("t1-valid", outValidA, 1);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    modelCycle("t1-idle");

    // Mismatch halts, err_clr resumes
    applyStimulus(5'b11111, 5'b11110, 1'b1, 1'b1, 1'b0);
    modelCycle("t2-bad");
    checkOutput("t2-mismatch", misA, 1);
    checkOutput("t2-err_cnt", errA, 1);
    checkOutput("t2-halted", haltA, 1);
    checkOutput("t2-in_ready", inRdyA, 0);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    modelCycle("t2-hold");
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    modelCycle("t2-clr");
    checkOutput("t2-unhalted", haltA, 0);
    checkOutput("t2-cleared", errA, 0);
    checkOutput("t2-ready", inRdyA, 1);

    // Fill with downstream stalled: 6 offered, 4 accepted
    for (int k = 0; k < 6; k++) begin
      ra   = 5'($urandom);
      w[k] = ra;
    end
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(w[idx], rev5(w[idx]), 1'b1, 1'b0, 1'b0);
      modelCycle("t3-fill");
      if (lastAcc) idx++;
    end
    checkOutput("t3-full-ready", inRdyA, 0);
    checkOutput("t3-full-valid", outValidA, 1);
    for (int c = 0; c < 30 && (idx < 6 || q.size() != 0); c++) begin
      if (idx < 6) applyStimulus(w[idx], rev5(w[idx]), 1'b1, 1'b1, 1'b0);
      else         applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      modelCycle("t3-drain");
      if (lastAcc) idx++;
    end
    checkOutput("t3-all-accepted", idx, 6);
    checkOutput("t3-drained", outValidA, 0);

    // Streaming throughput
    for (int c = 0; c < 20; c++) begin
      ra = 5'($urandom);
      applyStimulus(ra, rev5(ra), 1'b1, 1'b1, 1'b0);
      modelCycle("t4-stream");
      checkOutput("t4-accept", lastAcc, 1);
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    modelCycle("t4-tail");

    // Vector table on the non-halting instance
    pulseReset();
    @(posedge clk);
    #1;
    for (int k = 0; k < 7; k++) begin
      applyStimulus(vecs[k].a, vecs[k].b, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("vec-data", outDataB, vecs[k].expOut);
      checkOutput("vec-valid", outValidB, 1);
      checkOutput("vec-mismatch", misB, vecs[k].expMis);
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
    end

    // Saturation of a 2-bit counter, then clear racing a mismatch
    pulseReset();
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      ra = 5'($urandom);
      applyStimulus(ra, rev5(ra) ^ 5'b00100, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("t5-mismatch", misB, 1);
      checkOutput("t5-err_cnt", errB, (k + 1 > 3) ? 3 : k + 1);
    end
    applyStimulus(5'b00001, 5'b00001, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("t5-clr-cnt", errB, 0);
    checkOutput("t5-clr-mismatch", misB, 1);
    checkOutput("t5-not-halted", haltB, 0);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("t5-pulse-end", misB, 0);

    // Reset in the middle of buffered traffic
    pulseReset();
    modelCycle("t6-wake");
    for (int k = 0; k < 3; k++) begin
      ra = 5'($urandom);
      applyStimulus(ra, rev5(ra), 1'b1, 1'b0, 1'b0);
      modelCycle("t6-buffer");
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6-buffered", outValidA, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6-async-valid", outValidA, 0);
    checkOutput("t6-async-data", outDataA, 0);
    checkOutput("t6-async-ready", inRdyA, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    modelReset();
    modelCycle("t6-release");
    applyStimulus(5'b01100, 5'b00110, 1'b1, 1'b1, 1'b0);
    modelCycle("t6-word");
    checkOutput("t6-latency", outDataA, 10'b01100_00110);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    modelCycle("t6-after");

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      ra = 5'($urandom);
      applyStimulus(ra, ($urandom_range(0, 4) == 0) ? 5'($urandom) : rev5(ra),
                    1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7),
                    1'($urandom_range(0, 9) == 0));
      modelCycle("rand");
    end

    $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
